// File: rtl/pacman_screen_timing_pkg.sv
// Shared constants for the Pac-Man screen timing stage.
//   VGA_*    : 640x480@60 timing, sync polarity and line/frame totals.
//   PACMAN_* : native game resolution in game pixels.
//   sub_width(): width of a sub-pixel counter for a given scale (at least 1 bit).
package pacman_screen_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  localparam int PACMAN_GAME_W = 224;
  localparam int PACMAN_GAME_H = 288;

  function automatic int sub_width(int scale);
    return (scale > 1) ? $clog2(scale) : 1;
  endfunction

endpackage

// File: rtl/pacman_screen_timing_if.sv
// Video timing bundle from pacman_screen_timing to pacman_game.
//   master : driven by the timing generator
//   slave  : consumed by the renderer
// Signals: hsync, vsync (active low), display_enabled, game_area,
//          game_pix_stb, frame_stb, sx/sy game-space coordinates.
interface pacman_screen_timing_if
  import pacman_screen_timing_pkg::*;
#(
  parameter int GAME_W = PACMAN_GAME_W,
  parameter int GAME_H = PACMAN_GAME_H
) ();
  logic                       hsync;
  logic                       vsync;
  logic                       display_enabled;
  logic                       game_area;
  logic                       game_pix_stb;
  logic                       frame_stb;
  logic [$clog2(GAME_W)-1:0]  sx;
  logic [$clog2(GAME_H)-1:0]  sy;

  modport master (output hsync, vsync, display_enabled, game_area,
                  game_pix_stb, frame_stb, sx, sy);
  modport slave  (input  hsync, vsync, display_enabled, game_area,
                  game_pix_stb, frame_stb, sx, sy);
endinterface

// File: rtl/pacman_scale_counter.sv
// Sub-pixel / game-coordinate counter for one axis of the upscaled viewport.
//   vga_pix_clk, rst : clock, async active-low reset
//   en     : advance opportunity (every pixel for x, every line for y)
//   start  : position being entered is the first of the window; clears both
//   in_win : position being entered lies inside the window
//   sub    : sub-pixel index 0..SCALE-1
//   coord  : game coordinate, steps once per SCALE advances
module pacman_scale_counter
  import pacman_screen_timing_pkg::*;
#(
  parameter int SCALE   = 1,
  parameter int COORD_W = 8,
  parameter int SUB_W   = sub_width(SCALE)
) (
  input  logic               vga_pix_clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               in_win,
  output logic [SUB_W-1:0]   sub,
  output logic [COORD_W-1:0] coord
);

  always_ff @(posedge vga_pix_clk or negedge rst) begin
    if (!rst) begin
      sub   <= '0;
      coord <= '0;
    end else if (en) begin
      if (start) begin
        sub   <= '0;
        coord <= '0;
      end else if (in_win) begin
        if (sub == SUB_W'(SCALE - 1)) begin
          sub   <= '0;
          coord <= coord + 1'b1;
        end else begin
          sub <= sub + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pacman_screen_timing.sv
// VGA pixel-timing generator with a centred, integer-upscaled game viewport.
//   vga_pix_clk : pixel clock
//   rst         : async active-low reset
//   vid         : timing bundle (sync, visible/viewport flags, strobes, sx/sy)
// h/v hold the position that the output flops will present on the next edge,
// so after reset release the first edge shows (0,0). The axis counters track
// that same upcoming position and are therefore fed next-position flags.
module pacman_screen_timing
  import pacman_screen_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int GAME_W    = PACMAN_GAME_W,
  parameter int GAME_H    = PACMAN_GAME_H,
  parameter int SCALE     = 1
) (
  input logic                    vga_pix_clk,
  input logic                    rst,
  pacman_screen_timing_if.master vid
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_OFF   = (H_VISIBLE - GAME_W * SCALE) / 2;
  localparam int V_OFF   = (V_VISIBLE - GAME_H * SCALE) / 2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(GAME_W);
  localparam int YW      = $clog2(GAME_H);
  localparam int SW      = sub_width(SCALE);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_LEN   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_OFF_P  = HW'(H_OFF);
  localparam logic [HW-1:0] H_SPAN   = HW'(GAME_W * SCALE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_LEN   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_OFF_P  = VW'(V_OFF);
  localparam logic [VW-1:0] V_SPAN   = VW'(GAME_H * SCALE);

  if (SCALE < 1 || GAME_W * SCALE > H_VISIBLE || GAME_H * SCALE > V_VISIBLE) begin : g_bad_cfg
    $error("pacman_screen_timing: scaled game viewport does not fit the visible area");
  end

  logic [HW-1:0] h, h_next;
  logic [VW-1:0] v, v_next;
  logic          h_wrap;

  always_comb begin
    h_wrap = (h == H_LAST);
    h_next = h_wrap ? '0 : h + 1'b1;
    v_next = v;
    if (h_wrap) v_next = (v == V_LAST) ? '0 : v + 1'b1;
  end

  always_ff @(posedge vga_pix_clk or negedge rst) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_next;
      v <= v_next;
    end
  end

  // Window tests as (pos - start) < length: positions before the start wrap
  // to large unsigned values, so one compare covers both bounds.
  logic x_in, y_in, x_in_n, y_in_n;
  assign x_in   = (h - H_OFF_P) < H_SPAN;
  assign y_in   = (v - V_OFF_P) < V_SPAN;
  assign x_in_n = (h_next - H_OFF_P) < H_SPAN;
  assign y_in_n = (v_next - V_OFF_P) < V_SPAN;

  logic [SW-1:0] x_sub, y_sub;
  logic [XW-1:0] x_coord;
  logic [YW-1:0] y_coord;

  pacman_scale_counter #(.SCALE(SCALE), .COORD_W(XW)) u_x (
    .vga_pix_clk (vga_pix_clk),
    .rst         (rst),
    .en          (1'b1),
    .start       (h_next == H_OFF_P),
    .in_win      (x_in_n),
    .sub         (x_sub),
    .coord       (x_coord)
  );

  pacman_scale_counter #(.SCALE(SCALE), .COORD_W(YW)) u_y (
    .vga_pix_clk (vga_pix_clk),
    .rst         (rst),
    .en          (h_wrap),
    .start       (v_next == V_OFF_P),
    .in_win      (y_in_n),
    .sub         (y_sub),
    .coord       (y_coord)
  );

  always_ff @(posedge vga_pix_clk or negedge rst) begin
    if (!rst) begin
      vid.hsync           <= ~VGA_SYNC_ACTIVE;
      vid.vsync           <= ~VGA_SYNC_ACTIVE;
      vid.display_enabled <= 1'b0;
      vid.game_area       <= 1'b0;
      vid.game_pix_stb    <= 1'b0;
      vid.frame_stb       <= 1'b0;
      vid.sx              <= '0;
      vid.sy              <= '0;
    end else begin
      vid.hsync           <= ((h - HS_START) < HS_LEN) ? VGA_SYNC_ACTIVE : ~VGA_SYNC_ACTIVE;
      vid.vsync           <= ((v - VS_START) < VS_LEN) ? VGA_SYNC_ACTIVE : ~VGA_SYNC_ACTIVE;
      vid.display_enabled <= (h < H_VIS) && (v < V_VIS);
      vid.game_area       <= x_in && y_in;
      vid.game_pix_stb    <= x_in && y_in && (x_sub == '0) && (y_sub == '0);
      vid.frame_stb       <= (h == '0) && (v == '0);
      vid.sx              <= (x_in && y_in) ? x_coord : '0;
      vid.sy              <= (x_in && y_in) ? y_coord : '0;
    end
  end

endmodule
